// File: rtl/pid_pwm_drive_if.sv
// Signal bundle between the PID output stage and pid_pwm_drive.
// master drives the PID-side controls; slave is the PWM drive block.
interface pid_pwm_drive_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                i_en;
  logic [31:0]         i_un;
  logic                i_valid;
  logic                o_pwm;
  logic                o_dir;
  logic [PWM_BITS-1:0] o_duty;
  logic                o_sat;
  logic                o_fault;
  logic                o_period_start;

  modport master (
    output i_en, i_un, i_valid,
    input  o_pwm, o_dir, o_duty, o_sat, o_fault, o_period_start
  );

  modport slave (
    input  i_en, i_un, i_valid,
    output o_pwm, o_dir, o_duty, o_sat, o_fault, o_period_start
  );
endinterface

// File: rtl/pid_pwm_drive.sv
// Converts the PID control word into a saturated magnitude/direction pair and
// drives a glitch-free PWM with period-boundary duty updates and a sample watchdog.
module pid_pwm_drive #(
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned UN_SHIFT        = 4,
  parameter int unsigned TIMEOUT_PERIODS = 3
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pid_pwm_drive_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
  localparam int unsigned         WD_W     = (TIMEOUT_PERIODS == 0) ? 1 : $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [WD_W-1:0]     WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(TIMEOUT_PERIODS);

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d;
  logic                pend_dir_q, pend_dir_d;
  logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
  logic                act_dir_q, act_dir_d;
  logic                sat_q, sat_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                resume_q, resume_d;
  logic                pwm_q, pwm_d;
  logic                ps_q, ps_d;

  logic signed [32:0]  un_ext;
  logic signed [32:0]  un_scaled;
  logic [32:0]         un_mag;
  logic [PWM_BITS-1:0] conv_duty;
  logic                conv_dir;
  logic                conv_sat;
  logic                boundary;

  // 33-bit arithmetic keeps |0x80000000| representable when UN_SHIFT is 0
  always_comb begin
    un_ext    = {bus.i_un[31], bus.i_un};
    un_scaled = un_ext >>> UN_SHIFT;
    conv_dir  = un_scaled[32];
    un_mag    = conv_dir ? 33'(-un_scaled) : 33'(un_scaled);
    conv_sat  = un_mag > 33'(CNT_MAX);
    conv_duty = conv_sat ? CNT_MAX : un_mag[PWM_BITS-1:0];
  end

  assign boundary = (cnt_q == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_duty_q <= '0;
      pend_dir_q  <= 1'b0;
      act_duty_q  <= '0;
      act_dir_q   <= 1'b0;
      sat_q       <= 1'b0;
      wd_q        <= '0;
      resume_q    <= 1'b0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_duty_q <= pend_duty_d;
      pend_dir_q  <= pend_dir_d;
      act_duty_q  <= act_duty_d;
      act_dir_q   <= act_dir_d;
      sat_q       <= sat_d;
      wd_q        <= wd_d;
      resume_q    <= resume_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_duty_d = pend_duty_q;
    pend_dir_d  = pend_dir_q;
    act_duty_d  = act_duty_q;
    act_dir_d   = act_dir_q;
    sat_d       = sat_q;
    wd_d        = wd_q;
    resume_d    = resume_q;

    unique case (state_q)
      IDLE: begin
        cnt_d       = '0;
        pend_duty_d = '0;
        pend_dir_d  = 1'b0;
        act_duty_d  = '0;
        act_dir_d   = 1'b0;
        sat_d       = 1'b0;
        wd_d        = '0;
        resume_d    = 1'b0;
        if (bus.i_en) state_d = RUN;
      end
      RUN, FAULT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (bus.i_valid) begin
          pend_duty_d = conv_duty;
          pend_dir_d  = conv_dir;
          sat_d       = conv_sat;
        end
        // A sample arriving on the boundary cycle bypasses pending
        if (boundary) begin
          act_duty_d = bus.i_valid ? conv_duty : pend_duty_q;
          act_dir_d  = bus.i_valid ? conv_dir  : pend_dir_q;
        end
        if (state_q == RUN) begin
          if (bus.i_valid) begin
            wd_d = '0;
          end else if (boundary && (TIMEOUT_PERIODS != 0)) begin
            wd_d = wd_q + WD_ONE;
            if ((wd_q + WD_ONE) == WD_LIMIT) begin
              state_d = FAULT;
              wd_d    = '0;
            end
          end
        end else begin
          wd_d = '0;
          if (bus.i_valid) resume_d = 1'b1;
          if (boundary && (resume_q || bus.i_valid)) begin
            state_d  = RUN;
            resume_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.i_en) begin
      state_d     = IDLE;
      cnt_d       = '0;
      pend_duty_d = '0;
      pend_dir_d  = 1'b0;
      act_duty_d  = '0;
      act_dir_d   = 1'b0;
      sat_d       = 1'b0;
      wd_d        = '0;
      resume_d    = 1'b0;
    end

    // Outputs are registered from next-state values so they align with cnt_q
    pwm_d = (state_d == RUN) && (cnt_d < act_duty_d);
    ps_d  = (state_d != IDLE) && (cnt_d == '0);
  end

  assign bus.o_pwm          = pwm_q;
  assign bus.o_dir          = act_dir_q;
  assign bus.o_duty         = act_duty_q;
  assign bus.o_sat          = sat_q;
  assign bus.o_fault        = (state_q == FAULT);
  assign bus.o_period_start = ps_q;

endmodule

// File: doc/pid_pwm_drive.md
Name: pid_pwm_drive

Overview:
Downstream consumer of the PID core's control output (o_un / o_valid). Converts each signed 32-bit control word into a saturated magnitude plus a direction bit, then drives a glitch-free PWM output. New duty values are applied only at period boundaries. A watchdog forces the output off if the PID stops producing samples. Sits between pid_simple and the board pins.

Parameters:
PWM_BITS, 8, counter width; PWM period = 2^PWM_BITS clocks; duty range 0..2^PWM_BITS-1.
UN_SHIFT, 4, arithmetic right shift applied to i_un before saturation (fixed-point scaling); legal range 0..31.
TIMEOUT_PERIODS, 3, full periods without i_valid before fault; 0 disables the watchdog.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_en  in  1  drive enable; low forces IDLE.
i_un  in  32  signed control word from the PID.
i_valid  in  1  one-cycle strobe qualifying i_un.
o_pwm  out  1  PWM output.
o_dir  out  1  direction of the active duty; 1 = negative.
o_duty  out  PWM_BITS  active duty magnitude.
o_sat  out  1  the last captured sample was clamped.
o_fault  out  1  watchdog timeout active.
o_period_start  out  1  one-cycle pulse when the counter is 0.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; cnt, pending, active duty/dir, watchdog count = 0; all outputs 0.
- Conversion, combinational on i_un:
  - s = i_un >>> UN_SHIFT, computed at 33-bit signed width.
  - dir = s<0.
  - mag = |s|, computed in 33 bits so 0x80000000 with UN_SHIFT=0 does not overflow.
  - mag > 2^PWM_BITS-1 -> clamp to 2^PWM_BITS-1 and set sat=1; else sat=0.
- Capture: i_valid=1 in RUN or FAULT loads the pending {mag,dir} register and o_sat (registered, visible next cycle). i_valid is ignored in IDLE.
- Counter: in RUN and FAULT, cnt increments every clock and wraps from 2^PWM_BITS-1 to 0. In IDLE, cnt is held at 0.
- Boundary: on the cycle where cnt==2^PWM_BITS-1, active {duty,dir} <= pending.
  - If i_valid is also high that cycle, the incoming sample is used directly (bypass) and also written to pending.
- Output: o_pwm is registered, = (cnt < active duty) and state==RUN.
  - duty 0 -> constantly low.
  - duty 2^N-1 -> high 2^N-1 of 2^N cycles.
  - o_duty/o_dir reflect the active register.
- o_period_start is registered, high for the one cycle where cnt==0.
- States:
  - IDLE: o_pwm=0, pending/active cleared. Exits to RUN when i_en=1; cnt starts at 0 on the next cycle.
  - RUN: normal operation. Watchdog count increments at each wrap and clears on i_valid; a simultaneous valid and wrap clears it. When TIMEOUT_PERIODS!=0 and the count reaches TIMEOUT_PERIODS -> FAULT.
  - FAULT: o_fault=1, o_pwm=0, cnt keeps running. On i_valid the sample is captured and the FSM returns to RUN at the next boundary; o_fault clears and the new duty applies on that same edge.
  - i_en=0 in any state -> IDLE on the next edge, with o_pwm=0 the same edge. This overrides valid and boundary events.
- Mid-period updates never alter the current period; a partially generated period is never truncated except by i_en=0 or reset.
- Reset mid-period: all outputs drop to 0 immediately (async).

Test Plan:
1. PWM_BITS=8, UN_SHIFT=4, i_en=1; one i_valid with i_un=0x00000800 -> from the next period, o_duty=128, o_dir=0, o_sat=0, o_pwm high exactly 128 of each 256 cycles.
2. i_un=0xFFFFF800 (-2048) -> o_duty=128, o_dir=1. Then i_un=0x7FFFFFFF -> o_duty=255, o_sat=1. Then i_un=0x80000000 -> o_duty=255, o_dir=1, o_sat=1.
3. Mid-period update: duty=128 running; i_valid with duty 32 at cnt=50 -> the current period stays 128 high; the next period (after o_period_start) is 32 high. Repeat with i_valid at cnt=255 -> the next period is 32 (bypass).
4. Watchdog, TIMEOUT_PERIODS=3: no i_valid after the last sample -> o_fault=1 and o_pwm=0 after 3 wraps. Then i_valid with 0x400 -> o_fault clears at the next boundary and o_duty=64.
5. i_en dropped at cnt=100 while o_pwm=1 -> o_pwm=0 next edge, o_duty=0, cnt=0. i_en reasserted -> o_pwm stays 0 until a new i_valid is applied at a boundary.
6. i_rst_n pulsed low mid-period, asynchronous to the clock -> all outputs 0 immediately. After release, state is IDLE/RUN according to i_en, with no stale duty.
